// File: rtl/upstream_packet_deserializer_if.sv
// Upstream SIMD bus from a PE into the stack-side deserializer.
// The producer drives beats; the deserializer returns registered flow control.
interface upstream_packet_deserializer_if #(
    parameter int unsigned BUS_WIDTH = 64,
    parameter int unsigned OOB_WIDTH = 8
);
    logic                 sui__sti__valid;
    logic [1:0]           sui__sti__cntl;
    logic [1:0]           sui__sti__type;
    logic [BUS_WIDTH-1:0] sui__sti__data;
    logic [OOB_WIDTH-1:0] sui__sti__oob_data;
    logic                 sti__sui__ready;

    modport master (
        output sui__sti__valid, sui__sti__cntl, sui__sti__type, sui__sti__data, sui__sti__oob_data,
        input  sti__sui__ready
    );

    modport slave (
        input  sui__sti__valid, sui__sti__cntl, sui__sti__type, sui__sti__data, sui__sti__oob_data,
        output sti__sui__ready
    );
endinterface

// File: rtl/upstream_packet_deserializer.sv
// Rebuilds the lane-register array from SOM/MOM/EOM beats through a skid FIFO and ping-pong banks.
// Optional macro UPSTREAM_PACKET_DESERIALIZER_ERR_COUNT_EN adds a saturating error counter with clear.
module upstream_packet_deserializer #(
    parameter int unsigned NUM_LANES  = 32,
    parameter int unsigned LANE_WIDTH = 32,
    parameter int unsigned BUS_WIDTH  = 64,
    parameter int unsigned OOB_WIDTH  = 8,
    parameter int unsigned NUM_BEATS  = NUM_LANES * LANE_WIDTH / BUS_WIDTH,
    parameter int unsigned SKID_DEPTH = 4
) (
    input  logic                            clk,
    input  logic                            reset_poweron,
    upstream_packet_deserializer_if.slave   sui,
    output logic [NUM_LANES*LANE_WIDTH-1:0] upd__cons__regs,
    output logic [OOB_WIDTH-1:0]            upd__cons__tag,
    output logic                            upd__cons__valid,
    input  logic                            cons__upd__complete,
    output logic                            upd__err_protocol,
    output logic                            upd__err_overflow
`ifdef UPSTREAM_PACKET_DESERIALIZER_ERR_COUNT_EN
    ,
    output logic [15:0]                     upd__err_count,
    input  logic                            upd__err_count_clear
`endif
);

    localparam int unsigned ARR_W  = NUM_LANES * LANE_WIDTH;
    localparam int unsigned PTR_W  = (SKID_DEPTH > 1) ? $clog2(SKID_DEPTH) : 1;
    localparam int unsigned CNT_W  = $clog2(SKID_DEPTH + 1);
    localparam int unsigned BEAT_W = $clog2(NUM_BEATS);

    localparam logic [1:0] CNTL_MOM     = 2'b00;
    localparam logic [1:0] CNTL_SOM     = 2'b01;
    localparam logic [1:0] CNTL_EOM     = 2'b10;
    localparam logic [1:0] CNTL_SOM_EOM = 2'b11;
    localparam logic [1:0] TYPE_DATA    = 2'b00;

    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NUM_BEATS - 1);
    localparam logic [CNT_W-1:0]  READY_THR = CNT_W'(SKID_DEPTH - 3);
    localparam logic [CNT_W-1:0]  FIFO_MAX  = CNT_W'(SKID_DEPTH);
    localparam logic [PTR_W-1:0]  PTR_LAST  = PTR_W'(SKID_DEPTH - 1);

    typedef struct packed {
        logic [1:0]           cntl;
        logic [1:0]           ptype;
        logic [BUS_WIDTH-1:0] data;
        logic [OOB_WIDTH-1:0] oob;
    } beat_t;

    typedef enum logic [1:0] {ST_IDLE, ST_FILL, ST_DISCARD} state_e;

    // Skid FIFO
    beat_t             fifo_q [SKID_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              ready_q;
    beat_t             head, in_beat;
    logic              fifo_empty, fifo_full, pop_c, push_c, drop_c;

    // Fill FSM and banks
    state_e            state_q, state_d;
    logic [BEAT_W-1:0] beat_cnt_q, beat_cnt_d, wr_idx_c;
    logic              wr_en_c, tag_en_c, commit_c, proto_err_c, start_c;
    logic [1:0][NUM_BEATS-1:0][BUS_WIDTH-1:0] bank_q;
    logic [1:0][OOB_WIDTH-1:0] tag_bank_q;
    logic [1:0]        bank_full_q, bank_full_d, avail_c;
    logic              fill_q, fill_d, pres_q, pres_d, free_c;
    logic              valid_q, valid_d;
    logic [ARR_W-1:0]  regs_q;
    logic [OOB_WIDTH-1:0] tag_q;
    logic              err_proto_q, err_ovf_q;

    assign in_beat    = '{cntl: sui.sui__sti__cntl, ptype: sui.sui__sti__type,
                          data: sui.sui__sti__data, oob: sui.sui__sti__oob_data};
    assign head       = fifo_q[rd_ptr_q];
    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == FIFO_MAX);
    // Beats only leave the FIFO when there is a free bank to land in.
    assign pop_c      = !fifo_empty && !bank_full_q[fill_q];
    assign push_c     = sui.sui__sti__valid && (!fifo_full || pop_c);
    assign drop_c     = sui.sui__sti__valid && fifo_full && !pop_c;
    assign free_c     = cons__upd__complete && valid_q;

    always_comb begin
        count_d = count_q;
        case ({push_c, pop_c})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Next-state and bank-write decode for the beat at the FIFO head
    always_comb begin
        state_d     = state_q;
        beat_cnt_d  = beat_cnt_q;
        wr_en_c     = 1'b0;
        wr_idx_c    = '0;
        tag_en_c    = 1'b0;
        commit_c    = 1'b0;
        proto_err_c = 1'b0;
        start_c     = 1'b0;
        if (pop_c) begin
            case (state_q)
                ST_FILL: begin
                    case (head.cntl)
                        CNTL_MOM: begin
                            if (beat_cnt_q != LAST_BEAT) begin
                                wr_en_c    = 1'b1;
                                wr_idx_c   = beat_cnt_q;
                                beat_cnt_d = beat_cnt_q + 1'b1;
                            end else begin
                                proto_err_c = 1'b1;
                                state_d     = ST_DISCARD;
                            end
                        end
                        CNTL_EOM: begin
                            if (beat_cnt_q == LAST_BEAT) begin
                                wr_en_c  = 1'b1;
                                wr_idx_c = beat_cnt_q;
                                commit_c = 1'b1;
                            end else begin
                                proto_err_c = 1'b1;
                            end
                            state_d = ST_IDLE;
                        end
                        CNTL_SOM: begin
                            proto_err_c = 1'b1;
                            start_c     = 1'b1;
                        end
                        default: begin
                            proto_err_c = 1'b1;
                            state_d     = ST_IDLE;
                        end
                    endcase
                end
                ST_DISCARD: begin
                    case (head.cntl)
                        CNTL_SOM: start_c = 1'b1;
                        CNTL_EOM: state_d = ST_IDLE;
                        CNTL_SOM_EOM: begin
                            proto_err_c = 1'b1;
                            state_d     = ST_IDLE;
                        end
                        default: state_d = ST_DISCARD;
                    endcase
                end
                default: begin
                    if (head.cntl == CNTL_SOM) begin
                        start_c = 1'b1;
                    end else begin
                        proto_err_c = 1'b1;
                    end
                end
            endcase
            // A SOM restarts the fill at beat 0; non-data packets are skipped whole.
            if (start_c) begin
                if (head.ptype == TYPE_DATA) begin
                    wr_en_c    = 1'b1;
                    wr_idx_c   = '0;
                    tag_en_c   = 1'b1;
                    beat_cnt_d = BEAT_W'(1);
                    state_d    = ST_FILL;
                end else begin
                    state_d = ST_DISCARD;
                end
            end
        end
    end

    // Bank ownership; a freshly committed bank shows as valid one cycle after it is marked full
    always_comb begin
        bank_full_d = bank_full_q;
        fill_d      = fill_q;
        pres_d      = pres_q;
        avail_c     = bank_full_q;
        if (commit_c) begin
            bank_full_d[fill_q] = 1'b1;
            fill_d              = ~fill_q;
        end
        if (free_c) begin
            bank_full_d[pres_q] = 1'b0;
            avail_c[pres_q]     = 1'b0;
            pres_d              = ~pres_q;
        end
        valid_d = avail_c[pres_d];
    end

    always_ff @(posedge clk) begin
        if (push_c) begin
            fifo_q[wr_ptr_q] <= in_beat;
        end
    end

    always_ff @(posedge clk or posedge reset_poweron) begin
        if (reset_poweron) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            ready_q     <= 1'b0;
            state_q     <= ST_IDLE;
            beat_cnt_q  <= '0;
            bank_q      <= '0;
            tag_bank_q  <= '0;
            bank_full_q <= '0;
            fill_q      <= 1'b0;
            pres_q      <= 1'b0;
            valid_q     <= 1'b0;
            regs_q      <= '0;
            tag_q       <= '0;
            err_proto_q <= 1'b0;
            err_ovf_q   <= 1'b0;
        end else begin
            if (push_c) wr_ptr_q <= (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
            if (pop_c)  rd_ptr_q <= (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
            count_q     <= count_d;
            ready_q     <= (count_q <= READY_THR);
            state_q     <= state_d;
            beat_cnt_q  <= beat_cnt_d;
            if (wr_en_c)  bank_q[fill_q][wr_idx_c] <= head.data;
            if (tag_en_c) tag_bank_q[fill_q] <= head.oob;
            bank_full_q <= bank_full_d;
            fill_q      <= fill_d;
            pres_q      <= pres_d;
            valid_q     <= valid_d;
            regs_q      <= bank_q[pres_d];
            tag_q       <= tag_bank_q[pres_d];
            if (proto_err_c) err_proto_q <= 1'b1;
            if (drop_c)      err_ovf_q   <= 1'b1;
        end
    end

    assign sui.sti__sui__ready = ready_q;
    assign upd__cons__regs     = regs_q;
    assign upd__cons__tag      = tag_q;
    assign upd__cons__valid    = valid_q;
    assign upd__err_protocol   = err_proto_q;
    assign upd__err_overflow   = err_ovf_q;

`ifdef UPSTREAM_PACKET_DESERIALIZER_ERR_COUNT_EN
    logic [15:0] err_cnt_q;
    logic [1:0]  err_inc_c;
    logic [16:0] err_sum_c;

    assign err_inc_c = {1'b0, proto_err_c} + {1'b0, drop_c};
    assign err_sum_c = {1'b0, err_cnt_q} + 17'(err_inc_c);

    // Saturating count; a clear still records errors that land in the same cycle
    always_ff @(posedge clk or posedge reset_poweron) begin
        if (reset_poweron) begin
            err_cnt_q <= '0;
        end else if (upd__err_count_clear) begin
            err_cnt_q <= 16'(err_inc_c);
        end else if (err_sum_c[16]) begin
            err_cnt_q <= 16'hFFFF;
        end else begin
            err_cnt_q <= err_sum_c[15:0];
        end
    end

    assign upd__err_count = err_cnt_q;
`endif

endmodule

// File: tb/tb_upstream_packet_deserializer.sv
// Scoreboard bench for upstream_packet_deserializer: packets queued when driven, checked when presented.
// Covers latency, back-pressure, overflow, protocol errors, async reset and the optional error counter.
module tb_upstream_packet_deserializer;

    localparam int unsigned NB = 16;

    localparam logic [1:0] MOM  = 2'b00;
    localparam logic [1:0] SOM  = 2'b01;
    localparam logic [1:0] EOM  = 2'b10;
    localparam logic [1:0] DATA = 2'b00;

    typedef struct {
        logic [7:0]    tag;
        logic [1023:0] regs;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset_poweron = 1'b1;
    logic [1023:0] regs;
    logic [7:0]    tag;
    logic          valid, err_proto, err_ovf;
    logic          complete_mon = 1'b0, complete_man = 1'b0;
    wire           complete = complete_mon | complete_man;
    bit            cons_en = 1'b0;
    int            n_checks = 0, n_errs = 0;
    exp_t          sb[$];
`ifdef UPSTREAM_PACKET_DESERIALIZER_ERR_COUNT_EN
    logic [15:0]   err_count;
    logic          err_clear = 1'b0;
`endif

    upstream_packet_deserializer_if #(.BUS_WIDTH(64), .OOB_WIDTH(8)) sui ();

    upstream_packet_deserializer dut (
        .clk                 (clk),
        .reset_poweron       (reset_poweron),
        .sui                 (sui),
        .upd__cons__regs     (regs),
        .upd__cons__tag      (tag),
        .upd__cons__valid    (valid),
        .cons__upd__complete (complete),
        .upd__err_protocol   (err_proto),
        .upd__err_overflow   (err_ovf)
`ifdef UPSTREAM_PACKET_DESERIALIZER_ERR_COUNT_EN
        ,
        .upd__err_count      (err_count),
        .upd__err_count_clear(err_clear)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h", name, obs, exp);
        end
    endtask

    // Called at posedge+1; leaves the beat on the bus for exactly one edge.
    task automatic drive_beat(input logic [1:0] cntl, input logic [1:0] ptype,
                              input logic [63:0] data, input logic [7:0] oob, input bit obey);
        int n = 0;
        if (obey) begin
            while (!sui.sti__sui__ready && n < 500) begin
                @(posedge clk); #1;
                n++;
            end
            if (!sui.sti__sui__ready) check("ready_timeout", 64'(sui.sti__sui__ready), 64'd1);
        end
        sui.sui__sti__valid    = 1'b1;
        sui.sui__sti__cntl     = cntl;
        sui.sui__sti__type     = ptype;
        sui.sui__sti__data     = data;
        sui.sui__sti__oob_data = oob;
        @(posedge clk); #1;
        sui.sui__sti__valid    = 1'b0;
    endtask

    task automatic send_pkt(input logic [7:0] ptag, input bit counting);
        exp_t        e;
        logic [63:0] beats [NB];
        e.tag  = ptag;
        e.regs = '0;
        for (int k = 0; k < NB; k++) begin
            beats[k] = counting ? {32'(k), 32'(k)} : {$urandom(), $urandom()};
            e.regs[k*64 +: 64] = beats[k];
        end
        sb.push_back(e);
        for (int k = 0; k < NB; k++) begin
            drive_beat((k == 0) ? SOM : ((k == NB - 1) ? EOM : MOM), DATA, beats[k], ptag, 1'b1);
        end
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while ((sb.size() != 0 || valid) && n < 400) begin
            @(posedge clk); #1;
            n++;
        end
        check(name, 64'(sb.size()), 64'd0);
        repeat (10) @(posedge clk);
        #1;
        check({name, "_idle"}, 64'(valid), 64'd0);
    endtask

    task automatic do_reset();
        cons_en = 1'b0;
        @(negedge clk);
        reset_poweron = 1'b1;
        repeat (2) @(negedge clk);
        reset_poweron = 1'b0;
        sb.delete();
        @(posedge clk); #1;
    endtask

    // Consumer: compares each presented array against the scoreboard, then pulses complete.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            complete_mon = 1'b0;
            if (cons_en && valid) begin
                if (sb.size() == 0) begin
                    check("unexpected_pkt", 64'(tag), 64'hFFFF);
                end else begin
                    e = sb.pop_front();
                    check("pkt_tag", 64'(tag), 64'(e.tag));
                    for (int k = 0; k < NB; k++) check("pkt_beat", regs[k*64 +: 64], e.regs[k*64 +: 64]);
                end
                complete_mon = 1'b1;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        int   n;
        sui.sui__sti__valid    = 1'b0;
        sui.sui__sti__cntl     = MOM;
        sui.sui__sti__type     = DATA;
        sui.sui__sti__data     = '0;
        sui.sui__sti__oob_data = '0;

        // Reset state
        #3;
        check("rst_valid", 64'(valid), 64'd0);
        check("rst_ready", 64'(sui.sti__sui__ready), 64'd0);
        check("rst_err_proto", 64'(err_proto), 64'd0);
        check("rst_err_ovf", 64'(err_ovf), 64'd0);
        check("rst_tag", 64'(tag), 64'd0);
        repeat (2) @(negedge clk);
        reset_poweron = 1'b0;
        @(posedge clk); #1;

        // Single packet: latency, lane placement, tag, release
        send_pkt(8'h5A, 1'b1);
        check("t1_valid_t1", 64'(valid), 64'd0);
        @(posedge clk); #1;
        check("t1_valid_t2", 64'(valid), 64'd0);
        @(posedge clk); #1;
        check("t1_valid_t3", 64'(valid), 64'd1);
        e = sb.pop_front();
        check("t1_lane0", 64'(regs[31:0]), 64'h0);
        check("t1_lane31", 64'(regs[31*32 +: 32]), 64'hF);
        check("t1_tag", 64'(tag), 64'h5A);
        for (int k = 0; k < NB; k++) check("t1_beat", regs[k*64 +: 64], e.regs[k*64 +: 64]);
        complete_man = 1'b1;
        @(posedge clk); #1;
        complete_man = 1'b0;
        check("t1_valid_drop", 64'(valid), 64'd0);

        // Back-to-back with stalled consumer
        fork
            begin
                send_pkt(8'h01, 1'b0);
                send_pkt(8'h02, 1'b0);
                send_pkt(8'h03, 1'b0);
            end
            begin
                repeat (60) @(posedge clk);
                #1;
                check("t2_ready_low", 64'(sui.sti__sui__ready), 64'd0);
                check("t2_no_ovf", 64'(err_ovf), 64'd0);
                check("t2_valid", 64'(valid), 64'd1);
                check("t2_first_tag", 64'(tag), 64'h01);
                cons_en = 1'b1;
            end
        join
        wait_drain("t2_drain");
        check("t2_no_ovf_end", 64'(err_ovf), 64'd0);

        // Ready-ignoring producer overflows the skid FIFO
        do_reset();
        send_pkt(8'h10, 1'b0);
        send_pkt(8'h11, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check("t3_ovf_before", 64'(err_ovf), 64'd0);
        for (int k = 0; k < 10; k++) drive_beat((k == 0) ? SOM : MOM, DATA, 64'(k), 8'h12, 1'b0);
        check("t3_ovf_after", 64'(err_ovf), 64'd1);
        check("t3_ready_low", 64'(sui.sti__sui__ready), 64'd0);
`ifdef UPSTREAM_PACKET_DESERIALIZER_ERR_COUNT_EN
        check("t3_err_count", 64'(err_count), 64'd6);
`endif
        cons_en = 1'b1;
        wait_drain("t3_drain");

        // Protocol errors: stray MOM, early EOM, SOM mid-packet
        do_reset();
        cons_en = 1'b1;
        check("t4_proto_before", 64'(err_proto), 64'd0);
        drive_beat(MOM, DATA, 64'h1, 8'h20, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        check("t4_proto_mom_idle", 64'(err_proto), 64'd1);
        for (int k = 0; k <= 5; k++) drive_beat((k == 0) ? SOM : ((k == 5) ? EOM : MOM), DATA, 64'(k), 8'h21, 1'b1);
        for (int k = 0; k < 8; k++) drive_beat((k == 0) ? SOM : MOM, DATA, 64'(k), 8'h22, 1'b1);
        send_pkt(8'h42, 1'b0);
        wait_drain("t4_drain");
        check("t4_no_ovf", 64'(err_ovf), 64'd0);

        // Asynchronous reset in the middle of a fill
        cons_en = 1'b0;
        send_pkt(8'h77, 1'b0);
        n = 0;
        while (!valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("t5_valid_pre", 64'(valid), 64'd1);
        for (int k = 0; k < 7; k++) drive_beat((k == 0) ? SOM : MOM, DATA, 64'(k), 8'h78, 1'b1);
        sui.sui__sti__valid = 1'b1;
        sui.sui__sti__cntl  = MOM;
        sui.sui__sti__data  = 64'h7;
        #3;
        reset_poweron = 1'b1;
        #1;
        check("t5_rst_valid", 64'(valid), 64'd0);
        check("t5_rst_ready", 64'(sui.sti__sui__ready), 64'd0);
        check("t5_rst_proto", 64'(err_proto), 64'd0);
        check("t5_rst_tag", 64'(tag), 64'd0);
        check("t5_rst_regs", regs[63:0], 64'd0);
        sui.sui__sti__valid = 1'b0;
        @(negedge clk);
        reset_poweron = 1'b0;
        sb.delete();
        @(posedge clk); #1;
        cons_en = 1'b1;
        send_pkt(8'h99, 1'b0);
        wait_drain("t5_drain");
        check("t5_proto_clean", 64'(err_proto), 64'd0);

`ifdef UPSTREAM_PACKET_DESERIALIZER_ERR_COUNT_EN
        // Error counter and clear
        do_reset();
        cons_en = 1'b1;
        for (int k = 0; k < 3; k++) drive_beat(MOM, DATA, 64'(k), 8'h00, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        check("t6_count3", 64'(err_count), 64'd3);
        err_clear = 1'b1;
        @(posedge clk); #1;
        err_clear = 1'b0;
        check("t6_cleared", 64'(err_count), 64'd0);
`endif

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule

// File: doc/upstream_packet_deserializer.md
Name: upstream_packet_deserializer

Overview:
- Receive end of the stack upstream bus. It accepts SOM/MOM/EOM-delimited data packets from a PE's SIMD upstream interface and rebuilds the full array of execution-lane registers. It then presents that array, with its OOB tag, to a downstream consumer (stack-side aggregation/NoC).
- A 4-entry skid FIFO absorbs the producer's registered-ready latency. Ping-pong register banks let a new packet fill while the consumer drains the previous one.

Parameters:
- NUM_LANES, 32, number of execution-lane registers per packet
- LANE_WIDTH, 32, bits per lane register
- BUS_WIDTH, 64, upstream data beat width; must divide NUM_LANES*LANE_WIDTH
- OOB_WIDTH, 8, OOB tag width
- NUM_BEATS, NUM_LANES*LANE_WIDTH/BUS_WIDTH (default 16), beats per packet; must be >= 2
- SKID_DEPTH, 4, input FIFO depth

Ports:
- clk  in  1  clock
- reset_poweron  in  1  asynchronous, active-high reset
- sui__sti__valid  in  1  beat valid; not qualified by ready, so every valid beat is taken
- sui__sti__cntl  in  2  COMMON_STD_INTF_CNTL SOM/MOM/EOM/SOM_EOM
- sui__sti__type  in  2  STACK_UP packet type
- sui__sti__data  in  BUS_WIDTH  beat data
- sui__sti__oob_data  in  OOB_WIDTH  tag
- sti__sui__ready  out  1  registered flow control to producer
- upd__cons__regs  out  NUM_LANES*LANE_WIDTH  flattened lane array; lane i at bits [i*LANE_WIDTH +: LANE_WIDTH]
- upd__cons__tag  out  OOB_WIDTH  tag captured at SOM
- upd__cons__valid  out  1  array and tag valid
- cons__upd__complete  in  1  consumer has taken the array
- upd__err_protocol  out  1  sticky protocol error
- upd__err_overflow  out  1  sticky skid overflow

Behaviour:
- Reset (asynchronous): all outputs are 0, including sti__sui__ready. FIFO is empty, both banks are free, FSM is in IDLE, and the fill/present bank pointers are 0.
- Ready: sti__sui__ready is registered and set to (fifo_count <= SKID_DEPTH-3). This leaves 2 beats of slack for the 1-cycle delay in the producer's view of ready.
- Skid FIFO:
  - Pushes on every valid beat.
  - A push while full drops the beat and sets upd__err_overflow.
  - Pops when the FSM is in IDLE/FILL and the fill bank is free.
  - A simultaneous push and pop when full succeeds.
- FSM states: IDLE, FILL, DISCARD.
- IDLE:
  - SOM with type DATA: write beat 0, capture the tag, beat_cnt=1, go to FILL.
  - SOM_EOM: set err_protocol and drop it (NUM_BEATS >= 2).
  - MOM/EOM: set err_protocol and drop it.
  - SOM with a non-DATA type: go to DISCARD.
- FILL:
  - MOM with beat_cnt < NUM_BEATS-1: write the beat, beat_cnt+1.
  - EOM with beat_cnt == NUM_BEATS-1: write the beat, mark the fill bank full, toggle the fill pointer, go to IDLE.
  - EOM early, or MOM at beat_cnt == NUM_BEATS-1: set err_protocol, discard the partial bank, go to IDLE (EOM) or DISCARD (MOM).
  - SOM in FILL: set err_protocol, abort the partial packet, restart the fill at beat 0 with the new tag.
- DISCARD: drop beats until EOM, then go to IDLE. A SOM in DISCARD is handled as in IDLE.
- Beat placement: beat k occupies lanes [k*BUS_WIDTH/LANE_WIDTH +: BUS_WIDTH/LANE_WIDTH], low lane in the LSBs.
- Present side:
  - upd__cons__valid is high whenever the present bank is full. Data and tag are stable while valid is high.
  - On cons__upd__complete && valid: the bank is freed and the present pointer toggles. Valid drops the next cycle, or stays high if the other bank is full.
  - complete while valid is low is ignored.
- Latency: an EOM beat on the bus in cycle t gives upd__cons__valid in cycle t+3, with the FIFO empty and the bank free.
- Both banks full: the FIFO stops popping and ready falls once count exceeds the threshold. No beat is lost unless the producer ignores ready.
- Error flags are sticky until reset.

Optional Feature:
- Macro: UPSTREAM_PACKET_DESERIALIZER_ERR_COUNT_EN.
- Defined:
  - Adds output upd__err_count (16 bits), a saturating count of protocol errors plus overflow drops. It holds at 16'hFFFF.
  - Adds input upd__err_count_clear (1 bit). It synchronously clears the count; if an error occurs in the same cycle, the count is set to 1.
- Undefined: the ports and logic are absent, and only the sticky flags exist.

Test Plan:
- Single packet, defaults: 16 beats (SOM, 14 MOM, EOM) with data 0x0..0xF replicated, tag 0x5A. Required: valid at EOM+3, lane 0 = 0x0, lane 31 = 0xF, tag 0x5A, valid drops 1 cycle after complete.
- Back-to-back: 3 packets with consumer complete held low. Required: 2 banks full, ready falls, third packet is held in FIFO/stalled with no overflow. Then complete pulses deliver packets in order with tags 1, 2, 3.
- Ready-ignoring producer: consumer stalled, 6 beats pushed after ready falls. Required: upd__err_overflow = 1 and the excess beats are dropped.
- Protocol errors: MOM in IDLE; EOM at beat 5; SOM mid-packet at beat 8 followed by a full packet. Required: err_protocol = 1, only the final complete packet is presented.
- Async reset: reset asserted mid-fill at beat 7, between clock edges. Required: outputs clear immediately; a subsequent clean packet is received correctly.
- With UPSTREAM_PACKET_DESERIALIZER_ERR_COUNT_EN defined: 3 protocol errors. Required: count = 3. Then clear. Required: count = 0.
